// File: rtl/gate_sensor_interface_if.sv
// Sensor/output bundle for the parking gate front end.
// master drives the beams and the full flag, slave reports events.
interface gate_sensor_interface_if;
  logic entry_sensor_a;
  logic entry_sensor_b;
  logic exit_sensor_a;
  logic exit_sensor_b;
  logic parking_full;
  logic entry_passed;
  logic exit_passed;
  logic entry_gate_open;
  logic exit_gate_open;
  logic entry_denied;
  logic sensor_fault;

  modport master (
    output entry_sensor_a,
    output entry_sensor_b,
    output exit_sensor_a,
    output exit_sensor_b,
    output parking_full,
    input  entry_passed,
    input  exit_passed,
    input  entry_gate_open,
    input  exit_gate_open,
    input  entry_denied,
    input  sensor_fault
  );

  modport slave (
    input  entry_sensor_a,
    input  entry_sensor_b,
    input  exit_sensor_a,
    input  exit_sensor_b,
    input  parking_full,
    output entry_passed,
    output exit_passed,
    output entry_gate_open,
    output exit_gate_open,
    output entry_denied,
    output sensor_fault
  );
endinterface

// File: rtl/gate_sensor_interface.sv
// Beam sensor conditioning and per-lane crossing FSMs.
// Optional lane watchdog enabled by SENSOR_TIMEOUT_EN.
module gate_sensor_interface #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input logic clk,
  input logic reset,
  gate_sensor_interface_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ARRIVE, CROSS, LEAVE, REVERSE, DENIED
  } lane_t;

  localparam logic [7:0] DB_LAST =
    8'(DEBOUNCE_CYCLES - 1);

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] filt;
  logic [7:0] cnt [4];

  assign raw = {bus.exit_sensor_b, bus.exit_sensor_a,
                bus.entry_sensor_b, bus.entry_sensor_a};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  function automatic lane_t lane_next(
    lane_t s, logic a, logic b, logic deny
  );
    lane_t n;
    n = s;
    case (s)
      IDLE:
        if (a && !b) n = deny ? DENIED : ARRIVE;
        else if (!a && b) n = REVERSE;
      ARRIVE:
        if (a && b) n = CROSS;
        else if (!a && !b) n = IDLE;
        else if (!a && b) n = REVERSE;
      CROSS:
        if (!a && b) n = LEAVE;
        else if (a && !b) n = ARRIVE;
        else if (!a && !b) n = IDLE;
      LEAVE:
        if (!a && !b) n = IDLE;
        else if (a && b) n = CROSS;
        else if (a && !b) n = ARRIVE;
      REVERSE, DENIED:
        if (!a && !b) n = IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  function automatic logic is_open(lane_t s);
    return (s == ARRIVE) || (s == CROSS) ||
           (s == LEAVE);
  endfunction

  lane_t en_state, en_raw_next, en_next;
  lane_t ex_state, ex_raw_next, ex_next;

  always_comb begin
    en_raw_next = lane_next(en_state, filt[0], filt[1],
                            bus.parking_full);
    ex_raw_next = lane_next(ex_state, filt[2], filt[3],
                            1'b0);
  end

`ifdef SENSOR_TIMEOUT_EN
  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  logic [15:0] en_wd;
  logic [15:0] ex_wd;
  logic        en_to;
  logic        ex_to;
  logic        fault_q;

  always_comb begin
    en_to = (en_state != IDLE) &&
            (en_raw_next == en_state) &&
            (en_wd == TO_LAST);
    ex_to = (ex_state != IDLE) &&
            (ex_raw_next == ex_state) &&
            (ex_wd == TO_LAST);
    en_next = en_to ? IDLE : en_raw_next;
    ex_next = ex_to ? IDLE : ex_raw_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_wd   <= '0;
      ex_wd   <= '0;
      fault_q <= 1'b0;
    end else begin
      en_wd <= (en_state == IDLE || en_next != en_state)
               ? 16'd0 : en_wd + 16'd1;
      ex_wd <= (ex_state == IDLE || ex_next != ex_state)
               ? 16'd0 : ex_wd + 16'd1;
      fault_q <= fault_q | en_to | ex_to;
    end
  end

  assign bus.sensor_fault = fault_q;
`else
  always_comb begin
    en_next = en_raw_next;
    ex_next = ex_raw_next;
  end

  assign bus.sensor_fault = 1'b0;
`endif

  logic en_pass_q, ex_pass_q;
  logic en_open_q, ex_open_q;
  logic en_deny_q;

  // Outputs are registered from next state so they align with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_state  <= IDLE;
      ex_state  <= IDLE;
      en_pass_q <= 1'b0;
      ex_pass_q <= 1'b0;
      en_open_q <= 1'b0;
      ex_open_q <= 1'b0;
      en_deny_q <= 1'b0;
    end else begin
      en_state  <= en_next;
      ex_state  <= ex_next;
      en_pass_q <= (en_state == LEAVE) &&
                   (en_raw_next == IDLE);
      ex_pass_q <= (ex_state == LEAVE) &&
                   (ex_raw_next == IDLE);
      en_open_q <= is_open(en_next);
      ex_open_q <= is_open(ex_next);
      en_deny_q <= (en_next == DENIED);
    end
  end

  assign bus.entry_passed    = en_pass_q;
  assign bus.exit_passed     = ex_pass_q;
  assign bus.entry_gate_open = en_open_q;
  assign bus.exit_gate_open  = ex_open_q;
  assign bus.entry_denied    = en_deny_q;

endmodule
